// File: rtl/load_store_unit_if.sv
// Request/response bus between the execute stage (master) and the load/store unit (slave).
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store stage in front of data_memory; sub-word stores use
// read-modify-write, loads are lane-extracted and sign/zero-extended.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic req_fault(input logic [1:0] size, input logic [1:0] lane);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = lane[0];
            SZ_WORD: f = (lane != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] lane);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{sh[7] & ~uns}}, sh[7:0]};
            SZ_HALF: res = {{16{sh[15] & ~uns}}, sh[15:0]};
            SZ_WORD: res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // A word store is the degenerate merge: full mask at lane 0.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {lane, 3'b000};
        return (word & ~mask) | ((wdata << {lane, 3'b000}) & mask);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;

    // Next-state and datapath decode; handshake outputs are derived from the next state.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    if (req_fault(bus.req_size, bus.req_addr[1:0])) begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        error_d = 1'b1;
                    end else begin
                        addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        if (!bus.req_store) begin
                            state_d = ST_LOAD;
                        end else if (bus.req_size == SZ_WORD) begin
                            state_d     = ST_WRITE;
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            state_d = ST_RMW_RD;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rdata_d = load_extract(mem_read_data, size_q, uns_q, lane_q);
                error_d = 1'b0;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_wdata_d = store_merge(mem_read_data, wdata_q, size_q, lane_q);
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d  = (state_d == ST_IDLE);
        valid_d  = (state_d == ST_RESP);
        mem_we_d = (state_d == ST_WRITE);
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.resp_valid    = valid_q;
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_error    = error_q;
    assign mem_address       = addr_q;
    assign mem_write_data    = mem_wdata_q;
    assign mem_write_enable  = mem_we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory reference model.
module tb_load_store_unit;
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] tbmem   [64]  = '{default: 32'h0};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_cnt   = 0;
    int          acc_cnt  = 0;
    int          resp_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = tbmem[mem_address[7:2]];

    // data_memory model plus transaction monitors
    always @(posedge clk) begin
        if (mem_write_enable) begin
            tbmem[mem_address[7:2]] <= mem_write_data;
            wr_cnt++;
            last_wr_addr = mem_address;
        end
        if (bus.req_valid && bus.req_ready && !reset) acc_cnt++;
        if (bus.resp_valid) resp_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a[7:0]) & 32'hFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Reference: byte-addressed memory, access width in bytes, natural alignment rule.
    task automatic model(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_err,
                         output int exp_lat, output int exp_wr);
        int nb;
        logic [63:0] v;
        nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        exp_err = (nb == 0) ? 1'b1 : ((int'(addr[7:0]) % nb) != 0);
        exp_rd  = 32'h0;
        exp_lat = 1;
        exp_wr  = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (st) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr[7:0]) + i] = wd[8*i +: 8];
            exp_lat = (nb == 4) ? 2 : 3;
            exp_wr  = 1;
        end else begin
            v = 64'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(addr[7:0]) + i];
            if (!uns && v[8*nb-1]) v = v | (~64'h0 << (8*nb));
            exp_rd  = v[31:0];
            exp_lat = 2;
        end
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat, exp_wr, wr0, lat;
        model(st, sz, uns, addr, wd, exp_rd, exp_err, exp_lat, exp_wr);
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        got = bus.resp_rdata;
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("rdata", bus.resp_rdata, exp_rd);
        check_eq("error", 32'(bus.resp_error), 32'(exp_err));
        check_eq("writes", 32'(wr_cnt - wr0), 32'(exp_wr));
        check_eq("mem_word", tbmem[addr[7:2]], ref_word(addr));
        if (exp_wr != 0) check_eq("wr_addr", last_wr_addr, {addr[31:2], 2'b00});
        @(posedge clk); #1;
        check_eq("resp_pulse", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        check_eq({tag, "_valid"}, 32'(bus.resp_valid), 32'd0);
        check_eq({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        check_eq({tag, "_error"}, 32'(bus.resp_error), 32'd0);
        check_eq({tag, "_maddr"}, mem_address, 32'd0);
        check_eq({tag, "_mwdata"}, mem_write_data, 32'd0);
        check_eq({tag, "_mwe"}, 32'(mem_write_enable), 32'd0);
    endtask

    initial begin
        logic [31:0] got, exp_rd;
        logic        exp_err;
        int          exp_lat, exp_wr, a0, r0, w0, busy, g, lat;

        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        check_eq("tp_word_load", got, 32'hDEADBEEF);

        // byte read-modify-write
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, got);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AB, got);
        check_eq("tp_rmw_word", tbmem[8], 32'h11AB3344);
        do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, got);
        check_eq("tp_byte_signed", got, 32'hFFFFFFAB);
        do_req(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, got);
        check_eq("tp_byte_unsigned", got, 32'h000000AB);

        // halfword loads
        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h80017FFF, got);
        do_req(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, got);
        check_eq("tp_half_lo", got, 32'h00007FFF);
        do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, got);
        check_eq("tp_half_hi", got, 32'hFFFF8001);

        // misaligned / illegal
        w0 = wr_cnt;
        do_req(1'b0, 2'd2, 1'b0, 32'h31, 32'h0, got);
        check_eq("tp_err_flag", 32'(bus.resp_error), 32'd1);
        do_req(1'b1, 2'd1, 1'b0, 32'h33, 32'h0000BEEF, got);
        do_req(1'b1, 2'd3, 1'b0, 32'h30, 32'h12345678, got);
        check_eq("tp_err_nowrite", 32'(wr_cnt - w0), 32'd0);
        check_eq("tp_err_mem", tbmem[12], 32'h80017FFF);

        // busy: valid held across a byte store, then a load of the same word
        wait_ready();
        a0 = acc_cnt;
        r0 = resp_cnt;
        model(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000C3, exp_rd, exp_err, exp_lat, exp_wr);
        bus.req_valid    = 1'b1;
        bus.req_store    = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h21;
        bus.req_wdata    = 32'h000000C3;
        @(posedge clk); #1;
        bus.req_store = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h20;
        busy = 0;
        g    = 0;
        while (!bus.req_ready && g < 10) begin
            busy++;
            @(posedge clk); #1;
            g++;
        end
        check_eq("busy_cycles", 32'(busy), 32'd3);
        model(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, exp_rd, exp_err, exp_lat, exp_wr);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        check_eq("b2b_latency", 32'(lat), 32'd2);
        check_eq("b2b_rdata", bus.resp_rdata, exp_rd);
        check_eq("b2b_rdata_const", bus.resp_rdata, 32'h11ABC344);
        @(posedge clk); #1;
        check_eq("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
        check_eq("b2b_resps", 32'(resp_cnt - r0), 32'd2);

        // reset during RMW_RD
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h55667788, got);
        wait_ready();
        w0 = wr_cnt;
        r0 = resp_cnt;
        bus.req_valid    = 1'b1;
        bus.req_store    = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h40;
        bus.req_wdata    = 32'h00000099;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs("midrst");
        repeat (5) @(posedge clk);
        #1;
        check_eq("midrst_writes", 32'(wr_cnt - w0), 32'd0);
        check_eq("midrst_resps", 32'(resp_cnt - r0), 32'd0);
        check_eq("midrst_mem", tbmem[16], 32'h55667788);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
